// File: rtl/uart_tx_arbiter_if.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter_if
// Byte handshake between the TX arbiter and a UART transmitter.
//   txData      [7:0] byte to send (arbiter -> UART), stable while txDataValid
//   txDataValid       one-cycle issue strobe (arbiter -> UART)
//   txBusy            UART is shifting a frame (UART -> arbiter)
// Modports: master = arbiter side, slave = UART side.
// -----------------------------------------------------------------------------
interface uart_tx_arbiter_if;
  logic [7:0] txData;
  logic       txDataValid;
  logic       txBusy;

  modport master (output txData, output txDataValid, input txBusy);
  modport slave  (input txData, input txDataValid, output txBusy);
endinterface

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
// Merges two byte streams (keyboard and debug) onto one UART transmitter.
// Each requester has a private FIFO; a four-state FSM grants round-robin,
// issues one byte, then waits for the UART busy flag to rise and fall.
//
// Parameters
//   FIFO_DEPTH  per-requester FIFO depth (power of 2, >= 2)
//   BUSY_WAIT   cycles to wait in WAIT_HI for txBusy before giving up
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   kbdData/kbdDataValid       keyboard byte + one-cycle push strobe
//   dbgData/dbgDataValid       debug byte + one-cycle push strobe
//   tx (master)                txData/txDataValid out, txBusy in
//   kbdFull/dbgFull            FIFO full, combinational from occupancy
//   kbdOverflow/dbgOverflow    one-cycle pulse after a dropped push
//   timeoutErr                 one-cycle pulse when BUSY_WAIT expires
// Optional feature
//   UART_TX_ARB_CRLF_EN        after a keyboard 0x0D completes, send 0x0A
//                              immediately, ahead of any arbitration
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int FIFO_DEPTH = 4,
  parameter int BUSY_WAIT  = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         kbdData,
  input  logic               kbdDataValid,
  input  logic [7:0]         dbgData,
  input  logic               dbgDataValid,
  uart_tx_arbiter_if.master  tx,
  output logic               kbdFull,
  output logic               dbgFull,
  output logic               kbdOverflow,
  output logic               dbgOverflow,
  output logic               timeoutErr
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(BUSY_WAIT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_HI, WAIT_LO} state_e;
  // Requester index doubles as the FIFO array index.
  typedef enum logic {REQ_KBD = 1'b0, REQ_DBG = 1'b1} req_e;

  // ---------------------------------------------------------------------------
  // Per-requester FIFOs (index 0 = kbd, 1 = dbg)
  // ---------------------------------------------------------------------------
  logic [7:0]    mem_q      [2][FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q   [2];
  logic [AW-1:0] rd_ptr_q   [2];
  logic [AW:0]   count_q    [2];
  logic [7:0]    push_data  [2];
  logic [1:0]    push_valid;
  logic [1:0]    push;
  logic [1:0]    pop;
  logic [1:0]    full;
  logic [1:0]    nonempty;
  logic [1:0]    overflow_q;

  assign push_data[0] = kbdData;
  assign push_data[1] = dbgData;
  assign push_valid   = {dbgDataValid, kbdDataValid};

  for (genvar r = 0; r < 2; r++) begin : g_flags
    assign full[r]     = (count_q[r] == (AW+1)'(FIFO_DEPTH));
    assign nonempty[r] = (count_q[r] != '0);
    // A pop in the same cycle frees the slot, so a push into a full FIFO is kept.
    assign push[r]     = push_valid[r] && (!full[r] || pop[r]);
  end

  // ---------------------------------------------------------------------------
  // FSM state and arbitration
  // ---------------------------------------------------------------------------
  state_e        state_q;
  req_e          last_grant_q;
  req_e          grant;
  logic [7:0]    tx_data_q;
  logic          tx_valid_q;
  logic          timeout_q;
  logic [CW-1:0] wait_cnt_q;
  logic          can_issue;
  logic          wait_expired;
  logic          byte_done;
  logic [7:0]    head_data;
`ifdef UART_TX_ARB_CRLF_EN
  logic          crlf_pending_q;
`endif

  // NOTE: always_comb assigns every output a default first so no latch is inferred.
  always_comb begin
    grant = REQ_KBD;
    if (nonempty == 2'b11) begin
      grant = (last_grant_q == REQ_DBG) ? REQ_KBD : REQ_DBG;
    end else if (nonempty[1]) begin
      grant = REQ_DBG;
    end
  end

  assign can_issue    = (state_q == IDLE) && !tx.txBusy && (nonempty != 2'b00);
  assign pop[0]       = can_issue && (grant == REQ_KBD);
  assign pop[1]       = can_issue && (grant == REQ_DBG);
  assign head_data    = mem_q[grant][rd_ptr_q[grant]];
  // Busy rising in the last counted cycle still wins over the timeout.
  assign wait_expired = (state_q == WAIT_HI) && !tx.txBusy &&
                        (wait_cnt_q == CW'(BUSY_WAIT - 1));
  assign byte_done    = wait_expired || ((state_q == WAIT_LO) && !tx.txBusy);

  // NOTE: storage array has no reset; the reset pointers/count make stale
  // contents unreachable, and leaving it unreset lets it map to plain RAM.
  always_ff @(posedge clk) begin
    for (int r = 0; r < 2; r++) begin
      if (push[r]) mem_q[r][wr_ptr_q[r]] <= push_data[r];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < 2; r++) begin
        wr_ptr_q[r] <= '0;
        rd_ptr_q[r] <= '0;
        count_q[r]  <= '0;
      end
      overflow_q <= '0;
    end else begin
      for (int r = 0; r < 2; r++) begin
        if (push[r]) wr_ptr_q[r] <= wr_ptr_q[r] + AW'(1);
        if (pop[r])  rd_ptr_q[r] <= rd_ptr_q[r] + AW'(1);
        case ({push[r], pop[r]})
          2'b10:   count_q[r] <= count_q[r] + (AW+1)'(1);
          2'b01:   count_q[r] <= count_q[r] - (AW+1)'(1);
          default: ;
        endcase
        overflow_q[r] <= push_valid[r] && !push[r];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      last_grant_q   <= REQ_DBG;
      tx_data_q      <= 8'h00;
      tx_valid_q     <= 1'b0;
      timeout_q      <= 1'b0;
      wait_cnt_q     <= '0;
`ifdef UART_TX_ARB_CRLF_EN
      crlf_pending_q <= 1'b0;
`endif
    end else begin
      tx_valid_q <= 1'b0;
      timeout_q  <= wait_expired;
      case (state_q)
        IDLE: begin
          if (can_issue) begin
            tx_data_q    <= head_data;
            tx_valid_q   <= 1'b1;
            last_grant_q <= grant;
            state_q      <= ISSUE;
`ifdef UART_TX_ARB_CRLF_EN
            crlf_pending_q <= (grant == REQ_KBD) && (head_data == 8'h0D);
`endif
          end
        end
        ISSUE: begin
          wait_cnt_q <= '0;
          state_q    <= WAIT_HI;
        end
        WAIT_HI: begin
          if (tx.txBusy)         state_q    <= WAIT_LO;
          else if (!wait_expired) wait_cnt_q <= wait_cnt_q + CW'(1);
        end
        default: ;
      endcase
      if (byte_done) begin
`ifdef UART_TX_ARB_CRLF_EN
        // The LF bypasses arbitration so CR-LF reaches the UART as a pair.
        if (crlf_pending_q) begin
          tx_data_q      <= 8'h0A;
          tx_valid_q     <= 1'b1;
          crlf_pending_q <= 1'b0;
          state_q        <= ISSUE;
        end else begin
          state_q <= IDLE;
        end
`else
        state_q <= IDLE;
`endif
      end
    end
  end

  assign tx.txData      = tx_data_q;
  assign tx.txDataValid = tx_valid_q;
  assign kbdFull        = full[0];
  assign dbgFull        = full[1];
  assign kbdOverflow    = overflow_q[0];
  assign dbgOverflow    = overflow_q[1];
  assign timeoutErr     = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Directed bench for uart_tx_arbiter (default FIFO_DEPTH=4, BUSY_WAIT=16).
// Inputs change and outputs are sampled on the falling clock edge.
// The UART model raises txBusy 2 cycles after txDataValid and holds it for
// 10 cycles; it can also hold txBusy high or tie it low.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

  localparam int BW = 16;

  typedef enum int {BUSY_MODEL, BUSY_HOLD, BUSY_TIE0} busy_mode_e;

  logic       clk;
  logic       reset;
  logic [7:0] kbdData, dbgData;
  logic       kbdDataValid, dbgDataValid;
  logic       kbdFull, dbgFull, kbdOverflow, dbgOverflow, timeoutErr;

  uart_tx_arbiter_if tx_if ();

  uart_tx_arbiter #(.FIFO_DEPTH(4), .BUSY_WAIT(BW)) dut (
    .clk          (clk),
    .reset        (reset),
    .kbdData      (kbdData),
    .kbdDataValid (kbdDataValid),
    .dbgData      (dbgData),
    .dbgDataValid (dbgDataValid),
    .tx           (tx_if),
    .kbdFull      (kbdFull),
    .dbgFull      (dbgFull),
    .kbdOverflow  (kbdOverflow),
    .dbgOverflow  (dbgOverflow),
    .timeoutErr   (timeoutErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         cyc = 0;
  int         n_vec = 0;
  int         n_miss = 0;
  busy_mode_e busy_mode = BUSY_MODEL;
  int         busy_dly = 0;
  int         busy_hi = 0;
  logic [7:0] byte_q [$];
  int         stamp_q [$];
  int         to_q [$];
  int         kbd_ovf_n = 0;
  int         dbg_ovf_n = 0;

  always @(posedge clk) cyc++;

  // Monitor plus UART busy model.
  always @(negedge clk) begin
    if (tx_if.txDataValid) begin
      byte_q.push_back(tx_if.txData);
      stamp_q.push_back(cyc);
    end
    if (timeoutErr)  to_q.push_back(cyc);
    if (kbdOverflow) kbd_ovf_n++;
    if (dbgOverflow) dbg_ovf_n++;
    case (busy_mode)
      BUSY_HOLD: begin busy_dly = 0; busy_hi = 0; tx_if.txBusy = 1'b1; end
      BUSY_TIE0: begin busy_dly = 0; busy_hi = 0; tx_if.txBusy = 1'b0; end
      default: begin
        if (busy_hi > 0) busy_hi--;
        if (tx_if.txDataValid) busy_dly = 2;
        else if (busy_dly > 0) begin
          busy_dly--;
          if (busy_dly == 0) busy_hi = 10;
        end
        tx_if.txBusy = (busy_hi > 0);
      end
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic push(input logic k_en, input logic [7:0] k, input logic d_en, input logic [7:0] d);
    kbdData = k; kbdDataValid = k_en;
    dbgData = d; dbgDataValid = d_en;
    @(negedge clk);
    kbdDataValid = 1'b0;
    dbgDataValid = 1'b0;
  endtask

  // Mode changes at a rising edge so the model sees them at the next falling edge.
  task automatic set_mode(input busy_mode_e m);
    @(posedge clk);
    busy_mode = m;
    @(negedge clk);
  endtask

  task automatic wait_issued(input int n, input int budget, input string tag);
    int k = 0;
    while (byte_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, byte_q.size(), n);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    kbdDataValid = 1'b0;
    dbgDataValid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    byte_q.delete();
    stamp_q.delete();
    to_q.delete();
    kbd_ovf_n = 0;
    dbg_ovf_n = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p;
    reset = 1'b1;
    kbdData = 8'hEE; kbdDataValid = 1'b1;
    dbgData = 8'hDD; dbgDataValid = 1'b1;
    repeat (3) @(negedge clk);
    // Pushes presented during reset must be ignored.
    kbdDataValid = 1'b0; dbgDataValid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    check("rst_txData",      tx_if.txData, 8'h00);
    check("rst_txValid",     tx_if.txDataValid, 1'b0);
    check("rst_kbdFull",     kbdFull, 1'b0);
    check("rst_kbdOverflow", kbdOverflow, 1'b0);
    check("rst_timeout",     timeoutErr, 1'b0);
    repeat (20) @(negedge clk);
    check("rst_no_issue",    byte_q.size(), 0);

    // Scenario 1: single kbd byte, issued 2 cycles after its push.
    p = cyc;
    push(1'b1, 8'h41, 1'b0, 8'h00);
    wait_issued(1, 50, "s1_count");
    check("s1_byte",    byte_q[0], 8'h41);
    check("s1_latency", stamp_q[0] - p, 2);
    repeat (40) @(negedge clk);
    check("s1_one_pulse", byte_q.size(), 1);
    check("s1_no_ovf",    kbd_ovf_n, 0);

    // Scenario 2: simultaneous kbd/dbg pushes interleave round-robin, kbd first.
    do_reset();
    push(1'b1, 8'h31, 1'b1, 8'h61);
    push(1'b1, 8'h32, 1'b1, 8'h62);
    wait_issued(4, 200, "s2_count");
    check("s2_b0", byte_q[0], 8'h31);
    check("s2_b1", byte_q[1], 8'h61);
    check("s2_b2", byte_q[2], 8'h32);
    check("s2_b3", byte_q[3], 8'h62);
    check("s2_spacing", stamp_q[1] - stamp_q[0], 14);

    // Scenario 3: overflow with txBusy held high, then push+pop while full.
    repeat (20) @(negedge clk);
    set_mode(BUSY_HOLD);
    do_reset();
    push(1'b1, 8'h51, 1'b0, 8'h00);
    push(1'b1, 8'h52, 1'b0, 8'h00);
    push(1'b1, 8'h53, 1'b0, 8'h00);
    check("s3_notfull_3", kbdFull, 1'b0);
    push(1'b1, 8'h54, 1'b0, 8'h00);
    check("s3_full_4", kbdFull, 1'b1);
    push(1'b1, 8'h55, 1'b0, 8'h00);
    check("s3_ovf_pulse", kbdOverflow, 1'b1);
    check("s3_full_5",    kbdFull, 1'b1);
    @(negedge clk);
    check("s3_ovf_single", kbdOverflow, 1'b0);
    set_mode(BUSY_MODEL);
    // This push lands in the same cycle as the first pop of the full FIFO.
    push(1'b1, 8'h56, 1'b0, 8'h00);
    check("s3_pushpop_no_ovf", kbdOverflow, 1'b0);
    check("s3_pushpop_full",   kbdFull, 1'b1);
    wait_issued(5, 200, "s3_count");
    check("s3_b0", byte_q[0], 8'h51);
    check("s3_b1", byte_q[1], 8'h52);
    check("s3_b2", byte_q[2], 8'h53);
    check("s3_b3", byte_q[3], 8'h54);
    check("s3_b4", byte_q[4], 8'h56);
    repeat (40) @(negedge clk);
    check("s3_final_count", byte_q.size(), 5);
    check("s3_ovf_total",   kbd_ovf_n, 1);
    check("s3_dbg_ovf",     dbg_ovf_n, 0);

    // Scenario 4: txBusy never rises; timeout one ISSUE cycle plus BW
    // WAIT_HI cycles after each issue, bytes still each issued once.
    set_mode(BUSY_TIE0);
    do_reset();
    push(1'b1, 8'h71, 1'b1, 8'h72);
    wait_issued(2, 100, "s4_count");
    repeat (BW + 10) @(negedge clk);
    check("s4_b0",       byte_q[0], 8'h71);
    check("s4_b1",       byte_q[1], 8'h72);
    check("s4_to_count", to_q.size(), 2);
    check("s4_to0_delay", to_q[0] - stamp_q[0], BW + 1);
    check("s4_to1_delay", to_q[1] - stamp_q[1], BW + 1);
    repeat (40) @(negedge clk);
    check("s4_no_retry", byte_q.size(), 2);

    // Scenario 5: reset during WAIT_LO with 3 bytes still queued.
    set_mode(BUSY_MODEL);
    do_reset();
    push(1'b1, 8'h81, 1'b0, 8'h00);
    push(1'b1, 8'h82, 1'b0, 8'h00);
    push(1'b1, 8'h83, 1'b0, 8'h00);
    push(1'b1, 8'h84, 1'b0, 8'h00);
    wait_issued(1, 50, "s5_first");
    p = 0;
    while (cyc < stamp_q[0] + 5 && p < 50) begin
      @(negedge clk);
      p++;
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("s5_kbdFull", kbdFull, 1'b0);
    check("s5_valid",   tx_if.txDataValid, 1'b0);
    repeat (40) @(negedge clk);
    check("s5_discarded", byte_q.size(), 1);
    p = cyc;
    push(1'b1, 8'h85, 1'b0, 8'h00);
    wait_issued(2, 50, "s5_next");
    check("s5_next_byte",    byte_q[1], 8'h85);
    check("s5_next_latency", stamp_q[1] - p, 2);

    // Scenario 6: CR from kbd alongside a dbg byte.
    repeat (20) @(negedge clk);
    do_reset();
    push(1'b1, 8'h0D, 1'b1, 8'h58);
`ifdef UART_TX_ARB_CRLF_EN
    wait_issued(3, 200, "s6_count");
    check("s6_b0", byte_q[0], 8'h0D);
    check("s6_b1", byte_q[1], 8'h0A);
    check("s6_b2", byte_q[2], 8'h58);
    repeat (40) @(negedge clk);
    check("s6_final_count", byte_q.size(), 3);
`else
    wait_issued(2, 200, "s6_count");
    check("s6_b0", byte_q[0], 8'h0D);
    check("s6_b1", byte_q[1], 8'h58);
    repeat (40) @(negedge clk);
    check("s6_final_count", byte_q.size(), 2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter: FIFO_DEPTH, default 4, per-requester byte FIFO depth (power of 2, min 2).
REQ-002 Parameter: BUSY_WAIT, default 16, max clk cycles to wait for dataInTxBusy to rise after an issue.
REQ-003 clk  in  1  system clock (24MHz pixel/UART clock).
REQ-004 reset  in  1  synchronous active-high reset.
REQ-005 kbdData / kbdDataValid  in  8/1  keyboard ASCII byte; one-cycle push strobe.
REQ-006 dbgData / dbgDataValid  in  8/1  debug byte; one-cycle push strobe.
REQ-007 txBusy  in  1  UART transmitter busy (dataInTxBusy).
REQ-008 txData / txDataValid  out  8/1  byte and one-cycle issue strobe to the UART.
REQ-009 kbdFull / dbgFull  out  1/1  FIFO full flags, combinational from occupancy.
REQ-010 kbdOverflow / dbgOverflow  out  1/1  one-cycle pulse when a push is dropped.
REQ-011 timeoutErr  out  1  one-cycle pulse on a BUSY_WAIT expiry.

Function
REQ-012 Each requester has its own FIFO; a push when the FIFO is full is dropped, the FIFO is unchanged, and the overflow pulse fires in the next cycle.
REQ-013 A push and a pop on the same FIFO in the same cycle are both performed, including when full; the push is not dropped.
REQ-014 FSM states: IDLE, ISSUE, WAIT_HI, WAIT_LO.
REQ-015 IDLE: when txBusy=0 and at least one FIFO is non-empty, grant per REQ-016, pop the head into txData, go to ISSUE.
REQ-016 Arbitration is round-robin. With both FIFOs non-empty, grant the requester not granted last. With one FIFO non-empty, grant that one. The last-grant register resets to dbg, so kbd wins the first tie.
REQ-017 ISSUE: txDataValid=1 for exactly one cycle, txData held stable; next state WAIT_HI.
REQ-018 WAIT_HI: on txBusy=1 go to WAIT_LO. After BUSY_WAIT cycles without txBusy=1, pulse timeoutErr and return to IDLE; the byte is counted as sent and not retried.
REQ-019 WAIT_LO: on txBusy=0 return to IDLE. Minimum spacing between txDataValid pulses is therefore 4 cycles plus the UART frame time.
REQ-020 txData holds its last value outside ISSUE; txDataValid is 0 in every state except ISSUE.
REQ-021 FIFO pointers wrap modulo FIFO_DEPTH. Occupancy uses log2(FIFO_DEPTH)+1 bits, so full and empty are distinct.
REQ-022 Byte order within one requester is preserved. Bytes from the two requesters interleave only at byte boundaries.

Reset
REQ-023 Reset state: FSM=IDLE, both FIFOs empty, txData=0x00, txDataValid=0, all pulse outputs 0, last-grant=dbg, BUSY_WAIT counter=0.
REQ-024 Reset asserted mid-transfer aborts it immediately and discards all queued bytes. No txDataValid is issued in the reset cycle or the cycle after release.
REQ-025 Pushes presented while reset=1 are ignored and produce no overflow pulse.

Configuration
REQ-026 Macro: UART_TX_ARB_CRLF_EN.
REQ-027 Defined: when a kbd byte 0x0D completes (return from WAIT_LO or timeout), the FSM issues 0x0A next, before any arbitration. The pair is atomic and last-grant stays kbd; no FIFO slot is consumed for 0x0A.
REQ-028 Undefined: 0x0D is sent alone and there is no CR-LF pairing logic.

Verification
REQ-029 Bench txBusy model: rises 2 cycles after txDataValid, then stays high 10 cycles.
REQ-030 Scenario 1: push kbd 0x41 -> txData=0x41 with txDataValid in the cycle after the next IDLE grant; exactly one pulse; kbdOverflow never fires.
REQ-031 Scenario 2: push kbd 0x31,0x32 and dbg 0x61,0x62 in the same cycles -> UART order 0x31,0x61,0x32,0x62.
REQ-032 Scenario 3: 5 kbd pushes while txBusy is held high, FIFO_DEPTH=4 -> kbdFull=1 after the 4th, one kbdOverflow pulse on the 5th; first 4 bytes then emitted in order.
REQ-033 Scenario 4: txBusy tied 0 -> timeoutErr pulses BUSY_WAIT cycles after each ISSUE; all queued bytes are still issued once each.
REQ-034 Scenario 5: reset pulsed during WAIT_LO with 3 bytes queued -> no further txDataValid; kbdFull=0; next push is issued normally.
REQ-035 Scenario 6 (UART_TX_ARB_CRLF_EN defined): kbd 0x0D and dbg 0x58 queued together -> UART order 0x0D,0x0A,0x58.
